// File: rtl/rem_stream_if.sv
// Request/response bundle for rem_stream_sched: two valid/ready requesters,
// the exported serial bit stream, the result port and the FSM state for observation.
interface rem_stream_if #(
    parameter int WIDTH = 8,
    parameter int DIV   = 5
);
    localparam int RW = (DIV > 1) ? $clog2(DIV) : 1;

    // Handshake: a word moves on a rising edge where valid && ready are both high;
    // ready never waits for valid beyond the arbiter's choice, and valid/data must
    // stay stable until that edge.
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    logic             bit_en;
    logic             bit_x;
    logic             busy;
    logic             res_valid;
    logic             res_id;
    logic [RW-1:0]    res_rem;
    logic             res_div;
    logic [1:0]       state;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, bit_en, bit_x, busy,
        input  res_valid, res_id, res_rem, res_div, state
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, bit_en, bit_x, busy,
        output res_valid, res_id, res_rem, res_div, state
    );
endinterface

// File: rtl/rem_stream_sched.sv
// Round-robin two-requester front end for a serial MSB-first residue engine:
// one word in, WIDTH shift cycles, one result strobe carrying word mod DIV.
module rem_stream_sched #(
    parameter int WIDTH = 8,
    parameter int DIV   = 5
) (
    input  logic         clk,
    input  logic         rst,
    rem_stream_if.slave  bus
);
    localparam int RW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [RW:0]   DIV_V = (RW + 1)'(DIV);
    localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [RW-1:0]    rem;
    logic [RW-1:0]    rem_next;
    logic [RW:0]      rem_sum;
    logic [RW:0]      rem_sub;
    logic [CW-1:0]    cnt;
    logic             id;
    logic             last_grant;
    logic [RW-1:0]    out_rem;
    logic             out_div;
    logic             out_id;
    logic             grant;
    logic             any_valid;
    logic             ready0;
    logic             ready1;
    logic             accept0;
    logic             accept1;
    logic             accept;

    // Both valid: the side that did not win last time; a lone valid always wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        grant     = ~last_grant;
        if (bus.req0_valid && !bus.req1_valid) begin
            grant = 1'b0;
        end else if (bus.req1_valid && !bus.req0_valid) begin
            grant = 1'b1;
        end
        ready0  = (state_q == IDLE) && any_valid && !grant;
        ready1  = (state_q == IDLE) && any_valid && grant;
        accept0 = ready0 && bus.req0_valid;
        accept1 = ready1 && bus.req1_valid;
        accept  = accept0 | accept1;
    end

    // rem < DIV, so 2*rem+bit < 2*DIV and one conditional subtract reduces it.
    always_comb begin
        rem_sum  = {rem, shreg[WIDTH-1]};
        rem_sub  = rem_sum - DIV_V;
        rem_next = (rem_sum >= DIV_V) ? rem_sub[RW-1:0] : rem_sum[RW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (cnt == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            rem        <= '0;
            cnt        <= '0;
            id         <= 1'b0;
            last_grant <= 1'b1;
            out_rem    <= '0;
            out_div    <= 1'b0;
            out_id     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg      <= accept1 ? bus.req1_data : bus.req0_data;
                        rem        <= '0;
                        cnt        <= '0;
                        id         <= accept1;
                        last_grant <= accept1;
                    end
                end
                SHIFT: begin
                    rem   <= rem_next;
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    cnt   <= cnt + CW'(1);
                    // Result registers load on the DONE-entry edge and hold until the next one.
                    if (cnt == LAST) begin
                        out_rem <= rem_next;
                        out_div <= (rem_next == '0);
                        out_id  <= id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.req0_ready = ready0;
        bus.req1_ready = ready1;
        bus.bit_en     = (state_q == SHIFT);
        bus.bit_x      = (state_q == SHIFT) && shreg[WIDTH-1];
        bus.busy       = (state_q != IDLE);
        bus.res_valid  = (state_q == DONE);
        bus.res_rem    = out_rem;
        bus.res_div    = out_div;
        bus.res_id     = out_id;
        bus.state      = state_q;
    end
endmodule

// File: tb/tb_rem_stream_sched.sv
// Directed vector table and hand sequences for rem_stream_sched (8-bit, mod 5),
// plus a 12-bit mod 7 instance fed random words against an expected queue.
module tb_rem_stream_sched;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    time  acc_t;
    int   sweep_seen;
    logic [3:0] exp_q[$];

    rem_stream_if #(.WIDTH(8),  .DIV(5)) m_if ();
    rem_stream_if #(.WIDTH(12), .DIV(7)) s_if ();

    rem_stream_sched #(.WIDTH(8), .DIV(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if.slave)
    );

    rem_stream_sched #(.WIDTH(12), .DIV(7)) dut_sweep (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    typedef struct {
        bit         id;
        logic [7:0] data;
        logic [2:0] rem;
        bit         div;
    } vec_t;

    vec_t vecs[6];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver: raise valid, wait for ready, return 1 time unit after the accept edge
    task automatic m_drive(input bit who, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        if (who) begin
            m_if.req1_valid = 1'b1;
            m_if.req1_data  = d;
        end else begin
            m_if.req0_valid = 1'b1;
            m_if.req0_data  = d;
        end
        for (int i = 0; i < 40; i++) begin
            #1;
            if ((who ? m_if.req1_ready : m_if.req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            acc_t = $time;
            #1;
        end else begin
            check("accept_timeout", 0, 1);
        end
        if (who) m_if.req1_valid = 1'b0;
        else     m_if.req0_valid = 1'b0;
    endtask

    // follows one word from the cycle after its accept edge to the IDLE after DONE
    task automatic expect_result(input bit id, input logic [7:0] d, input logic [2:0] r, input bit dv);
        logic [7:0] bits;
        int en_cnt;
        int early;
        bits   = '0;
        en_cnt = 0;
        early  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bits[7-k] = m_if.bit_x;
            if (m_if.bit_en === 1'b1) en_cnt++;
            if (m_if.res_valid !== 1'b0) early++;
        end
        check("bit_stream", bits, d);
        check("bit_en_cycles", en_cnt, 8);
        check("res_valid_early", early, 0);
        @(negedge clk);
        check("res_valid_edge8", m_if.res_valid, 1);
        check("res_rem", m_if.res_rem, r);
        check("res_div", m_if.res_div, dv);
        check("res_id", m_if.res_id, id);
        check("bit_en_done", m_if.bit_en, 0);
        @(negedge clk);
        check("res_valid_one_cycle", m_if.res_valid, 0);
        check("idle_after_done", m_if.busy, 0);
        check("res_rem_hold", m_if.res_rem, r);
    endtask

    task automatic s_drive(input bit who, input logic [11:0] d);
        bit ok;
        ok = 1'b0;
        if (who) begin
            s_if.req1_valid = 1'b1;
            s_if.req1_data  = d;
        end else begin
            s_if.req0_valid = 1'b1;
            s_if.req0_data  = d;
        end
        for (int i = 0; i < 40; i++) begin
            #1;
            if ((who ? s_if.req1_ready : s_if.req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            check("sweep_accept_timeout", 0, 1);
        end
        s_if.req0_valid = 1'b0;
        s_if.req1_valid = 1'b0;
    endtask

    // scoreboard for the sweep instance
    always @(negedge clk) begin
        if (s_if.res_valid === 1'b1) begin
            sweep_seen++;
            if (exp_q.size() == 0) begin
                check("sweep_unexpected_result", 1, 0);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("sweep_rem", s_if.res_rem, e[2:0]);
                check("sweep_id", s_if.res_id, e[3]);
            end
        end
    end

    initial begin
        time t1;
        int  seen;
        checks     = 0;
        failures   = 0;
        sweep_seen = 0;
        m_if.req0_valid = 1'b0; m_if.req0_data = '0;
        m_if.req1_valid = 1'b0; m_if.req1_data = '0;
        s_if.req0_valid = 1'b0; s_if.req0_data = '0;
        s_if.req1_valid = 1'b0; s_if.req1_data = '0;

        vecs[0] = '{1'b0, 8'd25,  3'd0, 1'b1};
        vecs[1] = '{1'b1, 8'd13,  3'd3, 1'b0};
        vecs[2] = '{1'b0, 8'hFF,  3'd0, 1'b1};
        vecs[3] = '{1'b1, 8'd0,   3'd0, 1'b1};
        vecs[4] = '{1'b1, 8'd199, 3'd4, 1'b0};
        vecs[5] = '{1'b0, 8'd128, 3'd3, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_busy", m_if.busy, 0);
        check("reset_bit_en", m_if.bit_en, 0);
        check("reset_res_valid", m_if.res_valid, 0);
        check("reset_res_rem", m_if.res_rem, 0);
        check("reset_ready0", m_if.req0_ready, 0);
        check("reset_state", m_if.state, 0);
        @(negedge clk);

        // both valid straight after reset: req0 first, then req1, then req0 again
        m_if.req0_valid = 1'b1; m_if.req0_data = 8'd7;
        m_if.req1_valid = 1'b1; m_if.req1_data = 8'd9;
        #1;
        check("collide1_ready0", m_if.req0_ready, 1);
        check("collide1_ready1", m_if.req1_ready, 0);
        @(posedge clk);
        #1;
        m_if.req0_valid = 1'b0;
        check("busy_holds_ready1", m_if.req1_ready, 0);
        expect_result(1'b0, 8'd7, 3'd2, 1'b0);
        m_drive(1'b1, 8'd9);
        expect_result(1'b1, 8'd9, 3'd4, 1'b0);
        m_if.req0_valid = 1'b1; m_if.req0_data = 8'd3;
        m_if.req1_valid = 1'b1; m_if.req1_data = 8'd4;
        #1;
        check("collide2_ready0", m_if.req0_ready, 1);
        check("collide2_ready1", m_if.req1_ready, 0);
        @(posedge clk);
        #1;
        m_if.req0_valid = 1'b0;
        m_if.req1_valid = 1'b0;
        expect_result(1'b0, 8'd3, 3'd3, 1'b0);

        for (int i = 0; i < 6; i++) begin
            m_drive(vecs[i].id, vecs[i].data);
            expect_result(vecs[i].id, vecs[i].data, vecs[i].rem, vecs[i].div);
        end

        // back-to-back on req1 alone: one word per WIDTH+2 cycles
        m_drive(1'b1, 8'd11);
        t1 = acc_t;
        expect_result(1'b1, 8'd11, 3'd1, 1'b0);
        m_drive(1'b1, 8'd12);
        check("throughput_cycles", 32'((acc_t - t1) / 10), 10);
        expect_result(1'b1, 8'd12, 3'd2, 1'b0);

        // reset in the 4th SHIFT cycle drops the word
        m_drive(1'b0, 8'd200);
        repeat (4) @(negedge clk);
        check("pre_reset_bit_en", m_if.bit_en, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midshift_reset_busy", m_if.busy, 0);
        check("midshift_reset_bit_en", m_if.bit_en, 0);
        check("midshift_reset_res_rem", m_if.res_rem, 0);
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (m_if.res_valid !== 1'b0) seen++;
        end
        check("dropped_word_no_result", seen, 0);
        m_drive(1'b0, 8'd10);
        expect_result(1'b0, 8'd10, 3'd0, 1'b1);

        // 12-bit mod 7 instance with random words and requesters
        for (int n = 0; n < 100; n++) begin
            bit          who;
            logic [11:0] d;
            int          wait_cnt;
            who = 1'($urandom_range(0, 1));
            d   = 12'($urandom_range(0, 4095));
            exp_q.push_back({who, 3'(d % 12'd7)});
            s_drive(who, d);
            wait_cnt = 0;
            while (s_if.busy !== 1'b0 && wait_cnt < 40) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (wait_cnt >= 40) check("sweep_busy_timeout", 0, 1);
        end
        repeat (3) @(negedge clk);
        check("sweep_result_count", sweep_seen, 100);
        check("sweep_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
